// File: rtl/fb_pkg.sv
// Shared constants, FSM state type and index helper for the frame-buffer write arbiter.
// The CLEAR state exists only when FB_CLEAR_EN is defined.
package fb_pkg;

    localparam int SCR_W  = 96;
    localparam int SCR_H  = 64;
    localparam int COL_W  = 16;
    localparam int ADDR_W = 13;
    localparam int NREQ   = 3;
    localparam int XW     = 7;
    localparam int YW     = 6;

`ifdef FB_CLEAR_EN
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Three-way round-robin selector: first asserted request at or after ptr wins.
module rr_pick
    import fb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      grant,
    output logic            valid
);

    logic [1:0] idx1;
    logic [1:0] idx2;

    assign idx1 = next_idx(ptr);
    assign idx2 = next_idx(idx1);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        if (req[ptr]) begin
            grant = ptr;
            valid = 1'b1;
        end else if (req[idx1]) begin
            grant = idx1;
            valid = 1'b1;
        end else if (req[idx2]) begin
            grant = idx2;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter funnelling three pixel writers into one frame-buffer port.
// Optional FB_CLEAR_EN: after reset, zero-fill the whole buffer before serving requests.
module fb_write_arbiter #(
    parameter int SCR_W = fb_pkg::SCR_W,
    parameter int SCR_H = fb_pkg::SCR_H,
    parameter int COL_W = fb_pkg::COL_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [fb_pkg::NREQ-1:0]          req,
    input  logic [fb_pkg::NREQ*fb_pkg::XW-1:0] x_in,
    input  logic [fb_pkg::NREQ*fb_pkg::YW-1:0] y_in,
    input  logic [fb_pkg::NREQ*COL_W-1:0]    col_in,
    output logic [fb_pkg::NREQ-1:0]          ack,
    output logic                             wr_en,
    output logic [fb_pkg::ADDR_W-1:0]        wr_addr,
    output logic [COL_W-1:0]                 wr_data,
    output logic [fb_pkg::NREQ-1:0]          oob_err,
    output logic                             busy
);
    import fb_pkg::*;

    state_t            state;
    state_t            state_nx;
    logic [1:0]        ptr;
    logic [1:0]        grant;
    logic              pick_vld;
    logic [XW-1:0]     x_sel;
    logic [YW-1:0]     y_sel;
    logic [COL_W-1:0]  col_sel;
    logic              in_bnd;
    logic [ADDR_W-1:0] addr_sel;
    logic              wr_en_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [COL_W-1:0]  data_p1;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .valid (pick_vld)
    );

    always_comb begin
        x_sel   = x_in[XW-1:0];
        y_sel   = y_in[YW-1:0];
        col_sel = col_in[COL_W-1:0];
        case (grant)
            2'd1: begin
                x_sel   = x_in[2*XW-1:XW];
                y_sel   = y_in[2*YW-1:YW];
                col_sel = col_in[2*COL_W-1:COL_W];
            end
            2'd2: begin
                x_sel   = x_in[3*XW-1:2*XW];
                y_sel   = y_in[3*YW-1:2*YW];
                col_sel = col_in[3*COL_W-1:2*COL_W];
            end
            default: ;
        endcase
    end

    // Constant-coefficient multiply folds to shifts/adds; no divider involved.
    assign in_bnd   = (int'(x_sel) < SCR_W) && (int'(y_sel) < SCR_H);
    assign addr_sel = ADDR_W'(y_sel) * ADDR_W'(SCR_W) + ADDR_W'(x_sel);

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(SCR_W * SCR_H - 1);
    localparam state_t RST_STATE = CLEAR;
    logic [ADDR_W-1:0] clr_cnt;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= RST_STATE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (pick_vld) state_nx = WRITE;
            WRITE: state_nx = IDLE;
`ifdef FB_CLEAR_EN
            CLEAR: if (clr_cnt == CLR_LAST) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Grant stage: outputs are registered on the IDLE->WRITE edge so they are valid exactly during WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            ack      <= '0;
            wr_en_p1 <= 1'b0;
            addr_p1  <= '0;
            data_p1  <= '0;
            oob_err  <= '0;
        end else begin
            ack      <= '0;
            wr_en_p1 <= 1'b0;
            if (state == IDLE && pick_vld) begin
                ptr      <= next_idx(grant);
                ack      <= NREQ'(3'b001 << grant);
                wr_en_p1 <= in_bnd;
                addr_p1  <= addr_sel;
                data_p1  <= col_sel;
                if (!in_bnd) oob_err[grant] <= 1'b1;
            end
        end
    end

`ifdef FB_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst)                 clr_cnt <= '0;
        else if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
    end

    assign wr_en   = (state == CLEAR) | wr_en_p1;
    assign wr_addr = (state == CLEAR) ? clr_cnt : addr_p1;
    assign wr_data = (state == CLEAR) ? '0 : data_p1;
    assign busy    = (state != IDLE);
`else
    assign wr_en   = wr_en_p1;
    assign wr_addr = addr_p1;
    assign wr_data = data_p1;
    assign busy    = (state == WRITE);
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: vector table of single grants plus rotation and reset-abort sequences.
module tb_fb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [20:0] x_in;
    logic [17:0] y_in;
    logic [47:0] col_in;
    logic [2:0]  ack;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  oob_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fb_write_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .x_in    (x_in),
        .y_in    (y_in),
        .col_in  (col_in),
        .ack     (ack),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .oob_err (oob_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [20:0] x;
        logic [17:0] y;
        logic [47:0] col;
        logic [2:0]  ack;
        logic        en;
        logic [12:0] addr;
        logic [15:0] data;
        logic [2:0]  oob;
    } vec_t;

    vec_t tv[8];

    // Granted slot gets the real coordinates; other slots carry junk so a wrong mux select shows up.
    function automatic vec_t mkv(logic [2:0] r, int g, int xv, int yv, logic [15:0] c,
                                 logic en, int addr, logic [2:0] oob);
        vec_t v;
        v.req = r;
        v.x   = {3{7'h11}};
        v.y   = {3{6'h07}};
        v.col = {3{16'hDEAD}};
        v.x[7*g +: 7]    = 7'(xv);
        v.y[6*g +: 6]    = 6'(yv);
        v.col[16*g +: 16] = c;
        v.ack  = 3'(1 << g);
        v.en   = en;
        v.addr = 13'(addr);
        v.data = c;
        v.oob  = oob;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " ack"}, 32'(ack), 32'd0);
        chk({tag, " wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // ptr walks 0->1->0->2->1->0->2->0->1 across these vectors.
        tv[0] = mkv(3'b001, 0,   5,  2, 16'hF800, 1'b1,  197, 3'b000);
        tv[1] = mkv(3'b100, 2,  95, 63, 16'h07E0, 1'b1, 6143, 3'b000);
        tv[2] = mkv(3'b010, 1,   0,  0, 16'h001F, 1'b1,    0, 3'b000);
        tv[3] = mkv(3'b011, 0,  10,  1, 16'h1234, 1'b1,  106, 3'b000);
        tv[4] = mkv(3'b101, 2,   3,  3, 16'hABCD, 1'b1,  291, 3'b000);
        tv[5] = mkv(3'b010, 1,  96, 10, 16'hFFFF, 1'b0,    0, 3'b010);
        tv[6] = mkv(3'b100, 2, 100,  5, 16'h0F0F, 1'b0,    0, 3'b110);
        tv[7] = mkv(3'b001, 0,  95,  0, 16'h5555, 1'b1,   95, 3'b110);

        rst = 1'b1; req = '0; x_in = '0; y_in = '0; col_in = '0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset wr_en", 32'(wr_en), 32'd0);
        chk("reset wr_addr", 32'(wr_addr), 32'd0);
        chk("reset wr_data", 32'(wr_data), 32'd0);
        chk("reset oob_err", 32'(oob_err), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            req = tv[i].req; x_in = tv[i].x; y_in = tv[i].y; col_in = tv[i].col;
            step();
            chk($sformatf("v%0d ack", i), 32'(ack), 32'(tv[i].ack));
            chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(tv[i].en));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
            chk($sformatf("v%0d oob_err", i), 32'(oob_err), 32'(tv[i].oob));
            if (tv[i].en) begin
                chk($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(tv[i].addr));
                chk($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(tv[i].data));
            end
            req = '0;
            step();
            chk_quiet($sformatf("v%0d idle", i));
            chk($sformatf("v%0d oob hold", i), 32'(oob_err), 32'(tv[i].oob));
        end

        // Reset landing on a WRITE cycle: no ack/write afterwards, ptr back to 0, sticky flags cleared.
        x_in = {3{7'd1}}; y_in = {3{6'd1}}; col_in = {3{16'h0001}};
        req = 3'b010;
        step();
        chk("pre-abort ack", 32'(ack), 32'b010);
        rst = 1'b1;
        req = 3'b111;
        step();
        chk_quiet("abort");
        chk("abort oob_err", 32'(oob_err), 32'd0);
        rst = 1'b0;

        // Held 111: grants rotate 0,1,2,0 with one idle cycle between acks.
        for (int c = 0; c < 8; c++) begin
            logic [2:0] exp_ack;
            exp_ack = (c % 2 == 0) ? 3'(1 << ((c / 2) % 3)) : 3'b000;
            step();
            chk($sformatf("rotate c%0d ack", c), 32'(ack), 32'(exp_ack));
            chk($sformatf("rotate c%0d wr_en", c), 32'(wr_en), 32'(exp_ack != 3'b000));
        end
        req = '0;
        step();
        chk_quiet("final idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
